// File: rtl/ws2812_line_decoder.sv
// WS2812 receive decoder: recovers 24-bit GRB pixels, per-frame pixel index and
// end-of-frame events from a raw single-wire line sampled on clk.
//
// state     | meaning
// WAIT_IDLE | after reset or line error; needs T_RESET clean low cycles
// IDLE      | between frames, waiting for the first rise
// HIGH      | measuring a high pulse
// LOW       | inter-bit gap, or end-of-frame once T_RESET is reached
module ws2812_line_decoder #(
  parameter int T1_MIN     = 7,
  parameter int T_MAX_HIGH = 24,
  parameter int T_RESET    = 600,
  parameter int PIX_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             LEDS_LINE,
  output logic [23:0]      pixel_grb,
  output logic             pixel_valid,
  output logic [PIX_W-1:0] pixel_index,
  output logic             frame_done,
  output logic [PIX_W-1:0] frame_pixels,
  output logic             line_error
);

  localparam int HI_W = $clog2(T_MAX_HIGH + 1);
  localparam int LO_W = $clog2(T_RESET + 1);
  localparam logic [HI_W-1:0]  HI_ONE  = HI_W'(1);
  localparam logic [HI_W-1:0]  HI_LAST = HI_W'(T_MAX_HIGH - 1);
  localparam logic [HI_W-1:0]  T1_C    = HI_W'(T1_MIN);
  localparam logic [LO_W-1:0]  LO_ONE  = LO_W'(1);
  localparam logic [LO_W-1:0]  LO_MAX  = LO_W'(T_RESET);
  localparam logic [PIX_W-1:0] PIX_ONE = PIX_W'(1);
  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  typedef enum logic [1:0] {WAIT_IDLE = 2'd0, IDLE = 2'd1, HIGH = 2'd2, LOW = 2'd3} state_t;

  state_t state, state_nx;

  logic din_m, din_s, din_d;
  logic rise;

  logic [HI_W-1:0]  hi_cnt, hi_nx;
  logic [LO_W-1:0]  lo_cnt, lo_nx;
  logic [4:0]       bit_cnt, bit_nx;
  logic [PIX_W-1:0] pix_cnt, pix_nx;
  logic [23:0]      shreg, sh_nx, sh_shifted;
  logic [23:0]      grb_nx;
  logic [PIX_W-1:0] idx_nx, fpix_nx;
  logic             pv_nx, fd_nx, le_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
      din_d <= 1'b0;
    end else begin
      din_m <= LEDS_LINE;
      din_s <= din_m;
      din_d <= din_s;
    end
  end

  assign rise       = din_s & ~din_d;
  assign sh_shifted = {shreg[22:0], (hi_cnt >= T1_C)};

  always_comb begin
    state_nx = state;
    hi_nx    = hi_cnt;
    lo_nx    = lo_cnt;
    bit_nx   = bit_cnt;
    pix_nx   = pix_cnt;
    sh_nx    = shreg;
    grb_nx   = pixel_grb;
    idx_nx   = pixel_index;
    fpix_nx  = frame_pixels;
    pv_nx    = 1'b0;
    fd_nx    = 1'b0;
    le_nx    = 1'b0;

    case (state)
      WAIT_IDLE: begin
        if (lo_cnt == LO_MAX) begin
          // a rise arriving right as the idle completes starts a bit immediately
          if (din_s) begin
            state_nx = HIGH;
            hi_nx    = HI_ONE;
          end else begin
            state_nx = IDLE;
          end
        end else if (din_s) begin
          lo_nx = '0;
        end else begin
          lo_nx = lo_cnt + LO_ONE;
        end
      end

      IDLE: begin
        if (rise) begin
          state_nx = HIGH;
          hi_nx    = HI_ONE;
        end
      end

      HIGH: begin
        if (!din_s) begin
          sh_nx    = sh_shifted;
          state_nx = LOW;
          lo_nx    = LO_ONE;
          if (bit_cnt == 5'd23) begin
            grb_nx = sh_shifted;
            idx_nx = pix_cnt;
            pv_nx  = 1'b1;
            bit_nx = '0;
            if (pix_cnt != PIX_MAX) pix_nx = pix_cnt + PIX_ONE;
          end else begin
            bit_nx = bit_cnt + 5'd1;
          end
        end else if (hi_cnt == HI_LAST) begin
          // this sample is the T_MAX_HIGH-th consecutive high
          le_nx    = 1'b1;
          bit_nx   = '0;
          pix_nx   = '0;
          lo_nx    = '0;
          state_nx = WAIT_IDLE;
        end else begin
          hi_nx = hi_cnt + HI_ONE;
        end
      end

      LOW: begin
        if (lo_cnt == LO_MAX) begin
          fd_nx   = 1'b1;
          fpix_nx = pix_cnt;
          le_nx   = (bit_cnt != 5'd0);
          bit_nx  = '0;
          pix_nx  = '0;
          if (din_s) begin
            state_nx = HIGH;
            hi_nx    = HI_ONE;
          end else begin
            state_nx = IDLE;
          end
        end else if (din_s) begin
          state_nx = HIGH;
          hi_nx    = HI_ONE;
        end else begin
          lo_nx = lo_cnt + LO_ONE;
        end
      end

      default: state_nx = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_IDLE;
      hi_cnt       <= '0;
      lo_cnt       <= '0;
      bit_cnt      <= '0;
      pix_cnt      <= '0;
      shreg        <= '0;
      pixel_grb    <= '0;
      pixel_valid  <= 1'b0;
      pixel_index  <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      line_error   <= 1'b0;
    end else begin
      state        <= state_nx;
      hi_cnt       <= hi_nx;
      lo_cnt       <= lo_nx;
      bit_cnt      <= bit_nx;
      pix_cnt      <= pix_nx;
      shreg        <= sh_nx;
      pixel_grb    <= grb_nx;
      pixel_valid  <= pv_nx;
      pixel_index  <= idx_nx;
      frame_done   <= fd_nx;
      frame_pixels <= fpix_nx;
      line_error   <= le_nx;
    end
  end

endmodule

// File: tb/tb_ws2812_line_decoder.sv
// Directed bench for ws2812_line_decoder: drives hand-built WS2812 waveforms and
// checks decoded pixels, frame ends and line errors against hand-computed values.
module tb_ws2812_line_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line = 1'b0;
  logic [23:0] pixel_grb;
  logic        pixel_valid;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [7:0]  frame_pixels;
  logic        line_error;

  int tests = 0;
  int fails = 0;

  logic [23:0] q_grb[$];
  logic [7:0]  q_idx[$];
  logic [7:0]  q_fp[$];
  logic        q_fdle[$];
  int          n_le = 0;

  ws2812_line_decoder dut (
    .clk(clk), .rst_n(rst_n), .LEDS_LINE(line),
    .pixel_grb(pixel_grb), .pixel_valid(pixel_valid), .pixel_index(pixel_index),
    .frame_done(frame_done), .frame_pixels(frame_pixels), .line_error(line_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pixel_valid) begin
        q_grb.push_back(pixel_grb);
        q_idx.push_back(pixel_index);
      end
      if (frame_done) begin
        q_fp.push_back(frame_pixels);
        q_fdle.push_back(line_error);
      end
      if (line_error) n_le++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    q_grb.delete();
    q_idx.delete();
    q_fp.delete();
    q_fdle.delete();
    n_le = 0;
  endtask

  task automatic drive(input logic v, input int n);
    line = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bit period is 15 cycles; h0/h1 are the high times for '0'/'1'
  task automatic send_bits(input logic [23:0] d, input int n, input int h0, input int h1);
    int h;
    for (int i = 0; i < n; i++) begin
      h = d[23-i] ? h1 : h0;
      drive(1'b1, h);
      drive(1'b0, 15 - h);
    end
  endtask

  initial begin
    line  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grb",   pixel_grb,    0);
    check("rst_pv",    pixel_valid,  0);
    check("rst_idx",   pixel_index,  0);
    check("rst_fd",    frame_done,   0);
    check("rst_fpix",  frame_pixels, 0);
    check("rst_le",    line_error,   0);
    rst_n = 1'b1;

    // post-reset filter
    drive(1'b1, 100);
    drive(1'b0, 650);
    check("filt_pv",    q_grb.size(), 0);
    check("filt_fd",    q_fp.size(),  0);
    check("filt_le",    n_le,         0);
    check("filt_state", 32'(dut.state), 1);

    // single pixel with exact strobe latency on the last falling edge
    clear_log();
    send_bits(24'h123456, 23, 5, 10);
    drive(1'b1, 5);
    line = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("lat_pv_early", pixel_valid, 0);
    @(posedge clk);
    #1;
    check("lat_pv",  pixel_valid, 1);
    check("lat_grb", pixel_grb,   24'h123456);
    check("lat_idx", pixel_index, 0);
    drive(1'b0, 700);
    check("one_npv",  q_grb.size(), 1);
    check("one_nfd",  q_fp.size(),  1);
    check("one_fpix", q_fp[0],      1);
    check("one_le",   n_le,         0);

    // T1_MIN threshold: 6 high decodes '0', 7 high decodes '1'
    clear_log();
    send_bits(24'hFFFFFF, 24, 6, 6);
    send_bits(24'hFFFFFF, 24, 7, 7);
    drive(1'b0, 700);
    check("thr_npv",  q_grb.size(), 2);
    check("thr_g6",   q_grb[0],     24'h000000);
    check("thr_g7",   q_grb[1],     24'hFFFFFF);
    check("thr_fpix", q_fp[0],      2);

    // two frames back to back
    clear_log();
    send_bits(24'hFF0000, 24, 5, 10);
    send_bits(24'h00FF00, 24, 5, 10);
    send_bits(24'h0000FF, 24, 5, 10);
    drive(1'b0, 600);
    send_bits(24'hA5C3E7, 24, 5, 10);
    send_bits(24'h0F0F0F, 24, 5, 10);
    drive(1'b0, 700);
    check("mf_npv", q_grb.size(), 5);
    check("mf_g0",  q_grb[0], 24'hFF0000);
    check("mf_g1",  q_grb[1], 24'h00FF00);
    check("mf_g2",  q_grb[2], 24'h0000FF);
    check("mf_g3",  q_grb[3], 24'hA5C3E7);
    check("mf_g4",  q_grb[4], 24'h0F0F0F);
    check("mf_i0",  q_idx[0], 0);
    check("mf_i1",  q_idx[1], 1);
    check("mf_i2",  q_idx[2], 2);
    check("mf_i3",  q_idx[3], 0);
    check("mf_i4",  q_idx[4], 1);
    check("mf_nfd", q_fp.size(), 2);
    check("mf_fp0", q_fp[0], 3);
    check("mf_fp1", q_fp[1], 2);
    check("mf_le",  n_le, 0);

    // high timeout mid-pixel
    clear_log();
    send_bits(24'hABCDEF, 10, 5, 10);
    drive(1'b1, 30);
    drive(1'b0, 700);
    check("to_le",  n_le,         1);
    check("to_npv", q_grb.size(), 0);
    check("to_nfd", q_fp.size(),  0);

    // partial pixel at frame end
    clear_log();
    send_bits(24'hFFF000, 12, 5, 10);
    drive(1'b0, 700);
    check("part_nfd",  q_fp.size(),  1);
    check("part_fdle", q_fdle[0],    1);
    check("part_fpix", q_fp[0],      0);
    check("part_nle",  n_le,         1);
    check("part_npv",  q_grb.size(), 0);

    // reset in the middle of a frame
    clear_log();
    send_bits(24'h89ABCD, 24, 5, 10);
    send_bits(24'h555555, 10, 5, 10);
    drive(1'b1, 3);
    rst_n = 1'b0;
    #1;
    check("mrst_grb", pixel_grb,   0);
    check("mrst_idx", pixel_index, 0);
    check("mrst_pv",  pixel_valid, 0);
    check("mrst_fd",  frame_done,  0);
    check("mrst_le",  line_error,  0);
    check("mrst_npv", q_grb.size(), 1);
    line = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
    send_bits(24'h111111, 24, 5, 10);
    drive(1'b0, 100);
    check("mrst_noidle_npv", q_grb.size(), 0);
    drive(1'b0, 600);
    check("mrst_noidle_nfd", q_fp.size(), 0);
    send_bits(24'h654321, 24, 5, 10);
    drive(1'b0, 700);
    check("mrst_npv2", q_grb.size(), 1);
    check("mrst_g",    q_grb[0], 24'h654321);
    check("mrst_i",    q_idx[0], 0);
    check("mrst_fp",   q_fp[0],  1);
    check("mrst_nle",  n_le,     0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
